// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: shared constants and types for the set-associative tag
// controller (sa_tag_ctrl) and its replacement-state helper (sa_repl_state).
//   DEF_*     default geometry used as parameter defaults
//   fsm_e     controller state (IDLE / FLUSH)
//   sa_req_t  packed lookup request {tag, set, off} at the default geometry
package sa_cache_pkg;
  localparam int DEF_TAG_W = 26;
  localparam int DEF_SETS  = 4;
  localparam int DEF_WAYS  = 4;
  localparam int DEF_OFF_W = 2;
  localparam int DEF_SET_W = $clog2(DEF_SETS);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} fsm_e;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_SET_W-1:0] set;
    logic [DEF_OFF_W-1:0] off;
  } sa_req_t;
endpackage

// File: rtl/sa_repl_state.sv
// sa_repl_state: per-set replacement state and victim selection.
// Build option: define SA_TAG_PLRU_EN for tree pseudo-LRU (WAYS-1 bits/set,
// touched on hit and fill); otherwise a WAY_W-bit round-robin pointer per set
// that advances on every fill to that set.
// Ports:
//   clk, rst                 clock, async active-high reset (state -> 0)
//   look_set, look_valid     set being looked up and its valid bits
//   victim                   lowest invalid way, else replacement choice
//   hit_en/hit_set/hit_way   lookup hit (used by PLRU only)
//   fill_en/fill_set/fill_way accepted fill
module sa_repl_state
  import sa_cache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] look_set,
  input  logic [WAYS-1:0]  look_valid,
  output logic [WAY_W-1:0] victim,
  input  logic             hit_en,
  input  logic [SET_W-1:0] hit_set,
  input  logic [WAY_W-1:0] hit_way,
  input  logic             fill_en,
  input  logic [SET_W-1:0] fill_set,
  input  logic [WAY_W-1:0] fill_way
);

  logic [WAY_W-1:0] repl_way;

`ifdef SA_TAG_PLRU_EN
  localparam int NB = WAYS - 1;

  // Tree nodes are heap-numbered from 1; node n lives in bit n-1.
  // A node bit of 1 means "victim is in the right subtree".
  logic [SETS-1:0][NB-1:0] plru_q, plru_d;

  function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits,
                                               input logic [WAY_W-1:0] way);
    logic [NB-1:0]    r;
    logic [NB-1:0]    m;
    logic [WAY_W-1:0] wsh;
    int               node;
    r    = bits;
    wsh  = way;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      m = NB'(1) << (node - 1);
      // Point each node on the path away from the accessed way.
      if (wsh[WAY_W-1]) begin
        r    = r & ~m;
        node = 2 * node + 1;
      end else begin
        r    = r | m;
        node = 2 * node;
      end
      wsh = wsh << 1;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NB-1:0] bits);
    logic [NB-1:0] sh;
    int            node;
    node = 1;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = bits >> (node - 1);
      node = 2 * node + (sh[0] ? 1 : 0);
    end
    return WAY_W'(node - WAYS);
  endfunction

  // Hit and fill in one cycle: fill is applied last (most recent access).
  always_comb begin
    plru_d = plru_q;
    if (hit_en)  plru_d[hit_set]  = plru_touch(plru_d[hit_set], hit_way);
    if (fill_en) plru_d[fill_set] = plru_touch(plru_d[fill_set], fill_way);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) plru_q <= '0;
    else     plru_q <= plru_d;
  end

  assign repl_way = plru_victim(plru_q[look_set]);
`else
  logic [SETS-1:0][WAY_W-1:0] rr_q, rr_d;

  // WAY_W-bit wrap gives the mod-WAYS increment for free.
  always_comb begin
    rr_d = rr_q;
    if (fill_en) rr_d[fill_set] = rr_q[fill_set] + WAY_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  assign repl_way = rr_q[look_set];

  // Round-robin ignores hits.
  logic unused_hit;
  assign unused_hit = ^{hit_en, hit_set, hit_way};
`endif

  // Invalid ways take priority; scan downward so the lowest index wins.
  always_comb begin
    victim = repl_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!look_valid[w]) victim = WAY_W'(w);
  end

endmodule

// File: rtl/sa_tag_ctrl.sv
// sa_tag_ctrl: clocked 4-way (parametrised) set-associative tag controller.
// Owns tag/valid storage, answers lookups one cycle after acceptance, accepts
// fills, picks refill victims and runs an invalidate-all sweep (FLUSH).
// Build option: SA_TAG_PLRU_EN selects tree PLRU replacement (see
// sa_repl_state); default is per-set round-robin.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           lookup handshake (ready low during FLUSH)
//   req_tag/req_set/req_off       lookup request
//   rsp_valid/hit/miss/way/line   one-cycle registered result
//   rsp_victim                    refill way for this set
//   rsp_tag/rsp_set/rsp_off       registered request echo
//   fill_valid/set/way/tag        tag write (dropped during FLUSH)
//   inv_all                       start invalidate-all sweep
//   busy                          FLUSH in progress
module sa_tag_ctrl
  import sa_cache_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int SETS  = DEF_SETS,
  parameter int WAYS  = DEF_WAYS,
  parameter int OFF_W = DEF_OFF_W,
  localparam int SET_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic [SET_W-1:0]       req_set,
  input  logic [OFF_W-1:0]       req_off,
  output logic                   rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_miss,
  output logic [WAY_W-1:0]       rsp_way,
  output logic [SET_W+WAY_W-1:0] rsp_line,
  output logic [WAY_W-1:0]       rsp_victim,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [SET_W-1:0]       rsp_set,
  output logic [OFF_W-1:0]       rsp_off,
  input  logic                   fill_valid,
  input  logic [SET_W-1:0]       fill_set,
  input  logic [WAY_W-1:0]       fill_way,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic                   inv_all,
  output logic                   busy
);

  fsm_e             state_q;
  logic [SET_W-1:0] flush_cnt_q;
  logic             busy_q, req_ready_q;

  logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;

  logic             accept, fill_en;
  logic [WAYS-1:0]  look_valid, look_match;
  logic             look_hit;
  logic [WAY_W-1:0] look_way, look_victim;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
  logic [WAY_W-1:0] rsp_victim_q, rsp_victim_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [SET_W-1:0] rsp_set_q, rsp_set_d;
  logic [OFF_W-1:0] rsp_off_q, rsp_off_d;

  assign accept  = req_valid & req_ready_q;
  assign fill_en = fill_valid & (state_q == IDLE);

  // Lookup reads the current (pre-edge) arrays, so a same-cycle fill is
  // not visible to it.
  assign look_valid = valid_q[req_set];

  genvar gw;
  generate
    for (gw = 0; gw < WAYS; gw++) begin : g_match
      assign look_match[gw] = look_valid[gw] & (tag_q[req_set][gw] == req_tag);
    end
  endgenerate

  always_comb begin
    look_hit = 1'b0;
    look_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (look_match[w]) begin
        look_hit = 1'b1;
        look_way = WAY_W'(w);
      end
  end

  sa_repl_state #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_repl (
    .clk        (clk),
    .rst        (rst),
    .look_set   (req_set),
    .look_valid (look_valid),
    .victim     (look_victim),
    .hit_en     (accept & look_hit),
    .hit_set    (req_set),
    .hit_way    (look_way),
    .fill_en    (fill_en),
    .fill_set   (fill_set),
    .fill_way   (fill_way)
  );

  // Fills are gated off in FLUSH, so the sweep never races a write.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (fill_en) begin
      valid_d[fill_set][fill_way] = 1'b1;
      tag_d[fill_set][fill_way]   = fill_tag;
    end
    if (state_q == FLUSH) valid_d[flush_cnt_q] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  // Sweep FSM: one set per cycle, SETS cycles total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (inv_all) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
            busy_q      <= 1'b1;
            req_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q + SET_W'(1);
          if (flush_cnt_q == SET_W'(SETS - 1)) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Response fields are zero whenever no request was accepted.
  always_comb begin
    rsp_valid_d  = accept;
    rsp_hit_d    = accept & look_hit;
    rsp_way_d    = (accept & look_hit) ? look_way : '0;
    rsp_victim_d = accept ? look_victim : '0;
    rsp_tag_d    = accept ? req_tag : '0;
    rsp_set_d    = accept ? req_set : '0;
    rsp_off_d    = accept ? req_off : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_way_q    <= '0;
      rsp_victim_q <= '0;
      rsp_tag_q    <= '0;
      rsp_set_q    <= '0;
      rsp_off_q    <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_way_q    <= rsp_way_d;
      rsp_victim_q <= rsp_victim_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_set_q    <= rsp_set_d;
      rsp_off_q    <= rsp_off_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_miss   = rsp_valid_q & ~rsp_hit_q;
  assign rsp_way    = rsp_way_q;
  assign rsp_line   = {rsp_set_q, rsp_way_q};
  assign rsp_victim = rsp_victim_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_set    = rsp_set_q;
  assign rsp_off    = rsp_off_q;

endmodule

// File: tb/tb_sa_tag_ctrl.sv
// tb_sa_tag_ctrl: directed table, corner-case sequences and random traffic
// for sa_tag_ctrl, checked against a cache-level reference model.
module tb_sa_tag_ctrl;
  import sa_cache_pkg::*;

  localparam int TAG_W = DEF_TAG_W;
  localparam int SETS  = DEF_SETS;
  localparam int WAYS  = DEF_WAYS;
  localparam int OFF_W = DEF_OFF_W;
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid, req_ready;
  logic [TAG_W-1:0]       req_tag;
  logic [SET_W-1:0]       req_set;
  logic [OFF_W-1:0]       req_off;
  logic                   rsp_valid, rsp_hit, rsp_miss;
  logic [WAY_W-1:0]       rsp_way, rsp_victim;
  logic [SET_W+WAY_W-1:0] rsp_line;
  logic [TAG_W-1:0]       rsp_tag;
  logic [SET_W-1:0]       rsp_set;
  logic [OFF_W-1:0]       rsp_off;
  logic                   fill_valid;
  logic [SET_W-1:0]       fill_set;
  logic [WAY_W-1:0]       fill_way;
  logic [TAG_W-1:0]       fill_tag;
  logic                   inv_all, busy;

  sa_tag_ctrl #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_set(req_set), .req_off(req_off),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_miss(rsp_miss),
    .rsp_way(rsp_way), .rsp_line(rsp_line), .rsp_victim(rsp_victim),
    .rsp_tag(rsp_tag), .rsp_set(rsp_set), .rsp_off(rsp_off),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
    .fill_tag(fill_tag), .inv_all(inv_all), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_vld  [SETS][WAYS];
  logic [TAG_W-1:0] m_tag  [SETS][WAYS];
  int               m_fills[SETS];        // fills seen per set since reset
  int               m_plru [SETS][WAYS];  // tree nodes 1..WAYS-1
  int               m_flush_left, m_flush_set;

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_fills[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_vld[s][w]  = 1'b0;
        m_plru[s][w] = 0;
      end
    end
    m_flush_left = 0;
    m_flush_set  = 0;
  endtask

  task automatic m_touch(input int s, input int w);
`ifdef SA_TAG_PLRU_EN
    int node = 1;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      int dir = (w >> l) & 1;
      m_plru[s][node] = 1 - dir;
      node = 2 * node + dir;
    end
`else
    if (s < 0 || w < 0) $display("bad touch");
`endif
  endtask

  function automatic int m_victim(input int s);
    for (int w = 0; w < WAYS; w++)
      if (!m_vld[s][w]) return w;
`ifdef SA_TAG_PLRU_EN
    begin
      int node = 1;
      for (int l = 0; l < WAY_W; l++) node = 2 * node + m_plru[s][node];
      return node - WAYS;
    end
`else
    return m_fills[s] % WAYS;
`endif
  endfunction

  function automatic sa_req_t rq(input int t, input int s, input int o);
    sa_req_t r;
    r.tag = TAG_W'(t);
    r.set = SET_W'(s);
    r.off = OFF_W'(o);
    return r;
  endfunction

  // One clock: drive at negedge, check registered result #1 after posedge.
  task automatic step(input sa_req_t r, input bit rv, input bit fv, input int fs,
                      input int fw, input int ft, input bit inv);
    bit acc, eh;
    int ew, ev, rs;
    @(negedge clk);
    req_valid = rv; req_tag = r.tag; req_set = r.set; req_off = r.off;
    fill_valid = fv; fill_set = SET_W'(fs); fill_way = WAY_W'(fw);
    fill_tag = TAG_W'(ft); inv_all = inv;
    rs  = int'(r.set);
    acc = rv && (m_flush_left == 0);
    eh = 1'b0; ew = 0; ev = 0;
    if (acc) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_vld[rs][w] && m_tag[rs][w] == r.tag) begin eh = 1'b1; ew = w; end
      ev = m_victim(rs);
    end
    @(posedge clk);
    #1;
    if (acc && eh) m_touch(rs, ew);
    if (fv && m_flush_left == 0) begin
      m_tag[fs][fw] = TAG_W'(ft);
      m_vld[fs][fw] = 1'b1;
      m_fills[fs]++;
      m_touch(fs, fw);
    end
    if (m_flush_left > 0) begin
      for (int w = 0; w < WAYS; w++) m_vld[m_flush_set][w] = 1'b0;
      m_flush_set++;
      m_flush_left--;
    end else if (inv) begin
      m_flush_left = SETS;
      m_flush_set  = 0;
    end
    chk("rsp_valid", rsp_valid, acc);
    chk("rsp_hit", rsp_hit, eh);
    chk("rsp_miss", rsp_miss, acc && !eh);
    chk("rsp_way", rsp_way, ew);
    chk("rsp_line", rsp_line, acc ? rs * WAYS + ew : 0);
    chk("rsp_victim", rsp_victim, ev);
    chk("rsp_echo", {rsp_tag, rsp_set, rsp_off}, acc ? r : '0);
    chk("busy", busy, m_flush_left != 0);
    chk("req_ready", req_ready, m_flush_left == 0);
  endtask

  task automatic idle();
    step(rq(0, 0, 0), 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    sa_req_t rq;
    bit rv, fv;
    int fs, fw, ft;
    bit e_valid, e_hit;
    int e_way, e_line, e_vic;
  } vec_t;

  function automatic vec_t mk(input int t, input int s, input int o, input bit rv,
                              input bit fv, input int fs, input int fw, input int ft,
                              input bit ev, input bit eh, input int ew, input int el,
                              input int evic);
    vec_t v;
    v.rq = rq(t, s, o); v.rv = rv; v.fv = fv; v.fs = fs; v.fw = fw; v.ft = ft;
    v.e_valid = ev; v.e_hit = eh; v.e_way = ew; v.e_line = el; v.e_vic = evic;
    return v;
  endfunction

  vec_t tbl[7];
  int   nb;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk('h0000ABC, 2, 1, 1, 0, 0, 0, 0,         1, 0, 0, 8,  0); // cold miss
    tbl[1] = mk(0,         0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0,  0); // strobe drops
    tbl[2] = mk(0,         0, 0, 0, 1, 1, 3, 'h1234567, 0, 0, 0, 0,  0); // fill s1 w3
    tbl[3] = mk('h1234567, 1, 2, 1, 0, 0, 0, 0,         1, 1, 3, 7,  0); // hit line 7
    tbl[4] = mk('h2AAAAAA, 3, 3, 1, 1, 3, 0, 'h2AAAAAA, 1, 0, 0, 12, 0); // read-before-write
    tbl[5] = mk('h2AAAAAA, 3, 3, 1, 0, 0, 0, 0,         1, 1, 0, 12, 1); // now hits
    tbl[6] = mk(0,         0, 0, 1, 0, 0, 0, 0,         1, 0, 0, 0,  0); // invalid never hits

    rst = 1'b1;
    req_valid = 0; req_tag = '0; req_set = '0; req_off = '0;
    fill_valid = 0; fill_set = '0; fill_way = '0; fill_tag = '0; inv_all = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_miss", rsp_miss, 0);
    chk("reset_rsp_victim", rsp_victim, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rq, tbl[i].rv, tbl[i].fv, tbl[i].fs, tbl[i].fw, tbl[i].ft, 1'b0);
      chk($sformatf("tbl%0d_valid", i), rsp_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_hit", i), rsp_hit, tbl[i].e_hit);
      chk($sformatf("tbl%0d_way", i), rsp_way, tbl[i].e_way);
      chk($sformatf("tbl%0d_line", i), rsp_line, tbl[i].e_line);
      chk($sformatf("tbl%0d_victim", i), rsp_victim, tbl[i].e_vic);
    end

    // Full set 0, then replacement choice.
    for (int w = 0; w < WAYS; w++) step(rq(0, 0, 0), 1'b0, 1'b1, 0, w, 'h100 + w, 1'b0);
    step(rq('h3FF, 0, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);
`ifdef SA_TAG_PLRU_EN
    step(rq('h100, 0, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("plru_hit_way0", rsp_hit, 1);
    step(rq('h3FF, 0, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("plru_victim_not0", rsp_victim != 0, 1);
`else
    chk("rr_victim_full", rsp_victim, 0);
    step(rq(0, 0, 0), 1'b0, 1'b1, 0, 0, 'h100, 1'b0);
    step(rq('h3FF, 0, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("rr_victim_next", rsp_victim, 1);
`endif

    // Invalidate-all: exactly SETS busy cycles, fills dropped, all miss after.
    step(rq(0, 0, 0), 1'b0, 1'b1, 2, 2, 'h777, 1'b0);
    step(rq(0, 0, 0), 1'b0, 1'b0, 0, 0, 0, 1'b1);
    chk("flush_start_busy", busy, 1);
    chk("flush_start_ready", req_ready, 0);
    nb = 1;
    for (int i = 0; i < 10 && busy; i++) begin
      step(rq('h1234567, 1, 0), 1'b1, 1'b1, 2, 1, 'h55, 1'b0);
      if (busy) nb++;
    end
    chk("flush_len", nb, SETS);
    step(rq('h1234567, 1, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0); chk("post_flush_s1", rsp_miss, 1);
    step(rq('h2AAAAAA, 3, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0); chk("post_flush_s3", rsp_miss, 1);
    step(rq('h777, 2, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);     chk("post_flush_s2", rsp_miss, 1);
    step(rq('h55, 2, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);      chk("dropped_fill", rsp_miss, 1);
    for (int w = 0; w < WAYS; w++) begin
      step(rq('h100 + w, 0, 0), 1'b1, 1'b0, 0, 0, 0, 1'b0);
      chk("post_flush_s0", rsp_miss, 1);
    end

    // Reset in the second FLUSH cycle.
    step(rq(0, 0, 0), 1'b0, 1'b1, 1, 0, 'hAA, 1'b0);
    step(rq(0, 0, 0), 1'b0, 1'b1, 2, 3, 'hBB, 1'b0);
    step(rq(0, 0, 0), 1'b0, 1'b0, 0, 0, 0, 1'b1);
    idle();
    chk("mid_flush_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    m_reset();
    #2 rst = 1'b0;
    step(rq('hAA, 1, 1), 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("b2b_0_valid", rsp_valid, 1); chk("b2b_0_miss", rsp_miss, 1);
    step(rq('hBB, 2, 2), 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("b2b_1_valid", rsp_valid, 1); chk("b2b_1_miss", rsp_miss, 1);
    step(rq('hAA, 1, 3), 1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("b2b_2_valid", rsp_valid, 1); chk("b2b_2_miss", rsp_miss, 1);

    // Random traffic over a small tag pool so hits are frequent.
    for (int i = 0; i < 400; i++) begin
      step(rq('h200 + int'($urandom_range(0, 3)), int'($urandom_range(0, SETS - 1)),
              int'($urandom_range(0, 3))),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WAYS - 1)),
           'h200 + int'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < SETS + 1; i++) idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sa_tag_ctrl.md
Name: sa_tag_ctrl

Overview:
- Parametrised, clocked successor to the combinational 4-way set-associative lookup.
- Owns the tag/valid storage itself and performs a registered lookup over a valid/ready request handshake.
- Provides a fill port, per-set replacement victim selection and a multi-cycle invalidate-all sweep FSM.
- Sits between the core's load/store address split and the cache data-array/refill controller.

Parameters:
- TAG_W, 26, tag width in bits
- SETS, 4, number of sets (power of 2, >=2); SET_W = $clog2(SETS)
- WAYS, 4, ways per set (power of 2, 2..8); WAY_W = $clog2(WAYS)
- OFF_W, 2, block-offset width, passed through

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  request accepted when high; low during FLUSH
- req_tag  in  TAG_W  request tag
- req_set  in  SET_W  request set index
- req_off  in  OFF_W  request block offset
- rsp_valid  out  1  one-cycle response strobe
- rsp_hit  out  1  valid tag match
- rsp_miss  out  1  no valid match; equals rsp_valid & ~rsp_hit
- rsp_way  out  WAY_W  matching way; 0 on miss
- rsp_line  out  SET_W+WAY_W  global line number, set*WAYS+way
- rsp_victim  out  WAY_W  way to refill on miss
- rsp_tag, rsp_set, rsp_off  out  TAG_W/SET_W/OFF_W  registered echo of the request
- fill_valid  in  1  write a tag into storage
- fill_set  in  SET_W  set to write
- fill_way  in  WAY_W  way to write
- fill_tag  in  TAG_W  tag to write
- inv_all  in  1  pulse: invalidate whole cache
- busy  out  1  high while FLUSH is in progress

Behaviour:
- Reset (async):
  - All valid bits cleared; replacement state cleared (pointers/PLRU bits = 0).
  - FSM goes to IDLE.
  - Outputs: rsp_* = 0, req_ready = 1, busy = 0.
  - Tag array is not reset.
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH on inv_all; the flush counter loads 0.
  - FLUSH clears all valid bits of set[counter] each cycle, so it lasts exactly SETS cycles.
  - FLUSH -> IDLE after set SETS-1 is cleared; req_ready returns to 1 on the following cycle.
  - inv_all during FLUSH is ignored.
- Lookup:
  - Accepted on req_valid & req_ready; response appears exactly 1 cycle later with rsp_valid high for one cycle.
  - No response backpressure; back-to-back requests give back-to-back responses.
  - Hit requires valid[set][w] & tag match. Tag match on an invalid way never hits.
  - Multiple matches: lowest-index way wins.
- Victim selection (rsp_victim):
  - Lowest-index invalid way in the set if one exists.
  - Otherwise the replacement state of that set.
  - rsp_victim is valid on hits too, but is don't-care for consumers.
- Fill:
  - Takes effect at the clock edge: tag written, valid set, replacement state updated.
  - Fill in the same cycle as an accepted lookup to the same set: the lookup sees pre-fill contents (read-before-write).
  - Fill during FLUSH is dropped.
- Replacement update also occurs on each lookup hit (PLRU variant only).
- Width rule: rsp_line = {rsp_set, rsp_way}, zero-extension free.
- Reset asserted mid-FLUSH: immediate IDLE, all valid cleared, no partial state left.

Optional Feature:
- Macro SA_TAG_PLRU_EN.
- Defined: tree pseudo-LRU with WAYS-1 bits per set.
  - Updated on hit and on fill to point away from the accessed way.
  - Victim follows the tree bits.
- Undefined: per-set round-robin pointer of WAY_W bits.
  - Increments (mod WAYS) on every fill to that set.
  - Hits do not change it.

Decomposition:
- Package sa_cache_pkg holds:
  - Default constants TAG_W/SETS/WAYS/OFF_W.
  - typedef fsm_e {IDLE, FLUSH}.
  - A packed request struct {tag, set, off}.
- One natural sub-module, sa_repl_state: per-set replacement storage plus victim computation. It contains both the PLRU and round-robin variants selected by the macro.

Test Plan:
- Reset, then lookup tag 0x0000ABC set 2 -> rsp_valid one cycle later, rsp_miss = 1, rsp_victim = 0; lookup with tag equal to uninitialised array contents still misses.
- Fill set 1 way 3 tag 0x1234567, then lookup the same -> rsp_hit = 1, rsp_way = 3, rsp_line = 7, echoes match.
- Fill all 4 ways of set 0 (RR build), then lookup a miss -> rsp_victim = 0; one more fill -> victim 1. PLRU build: hit way 0 then miss -> victim != 0.
- Same-cycle fill set 3 way 0 tag T and lookup set 3 tag T -> miss; repeat the lookup the next cycle -> hit way 0.
- Fill several sets, pulse inv_all -> busy and ~req_ready for exactly 4 cycles; fills in that window dropped; later lookups of the filled tags all miss.
- Assert rst in the 2nd FLUSH cycle -> busy = 0 and req_ready = 1 immediately; all lookups miss; back-to-back requests on consecutive cycles produce consecutive responses.
